tx_resp_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART TX FIFO write port among three response sources: the RF read-data path, the ALU result path and the status/error path. Each source hands over a one- or two-byte packet with a valid/ack handshake. The arbiter buffers the granted packet and writes it into the TX FIFO one byte per cycle, LSB first, honouring FIFO_FULL. Packets are atomic: bytes from different sources never interleave in the FIFO.

---
 rtl/tx_resp_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_tx_resp_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_resp_arbiter.sv
// tx_resp_arbiter: round-robin arbiter sharing one TX FIFO write port
// among three response sources (0 = RF read, 1 = ALU, 2 = status).
// A granted packet (one or two bytes) is buffered and written LSB first,
// one byte per cycle, stalling on FIFO_FULL. Packets never interleave.
// Optional feature: define TX_ARB_HDR_EN to prefix every packet with a
// header byte {4'b1010, 1'b0, two, id[1:0]}, zero-extended to WIDTH.
module tx_resp_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ0_VLD,
    input  logic                 REQ1_VLD,
    input  logic                 REQ2_VLD,
    input  logic [2*WIDTH-1:0]   REQ0_DATA,
    input  logic [2*WIDTH-1:0]   REQ1_DATA,
    input  logic [2*WIDTH-1:0]   REQ2_DATA,
    input  logic                 REQ0_TWO,
    input  logic                 REQ1_TWO,
    input  logic                 REQ2_TWO,
    output logic                 REQ0_ACK,
    output logic                 REQ1_ACK,
    output logic                 REQ2_ACK,
    input  logic                 FIFO_FULL,
    output logic [WIDTH-1:0]     FIFO_WR_DATA,
    output logic                 FIFO_WR_INC,
    output logic                 BUSY
);

`ifdef TX_ARB_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_HDR = 2'd1,
        ST_SEND_LO  = 2'd2,
        ST_SEND_HI  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_LO  = 2'd2,
        ST_SEND_HI  = 2'd3
    } state_e;
`endif

    // Advance a round-robin index modulo 3; an illegal 3 folds back to 0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        logic [1:0] nxt;
        if (idx >= 2'd2) begin
            nxt = 2'd0;
        end else begin
            nxt = idx + 2'd1;
        end
        return nxt;
    endfunction

    // First valid source in search order ptr, ptr+1, ptr+2 (mod 3).
    // Returns {found, index[1:0]}.
    function automatic logic [2:0] rr_pick(input logic [2:0] vld, input logic [1:0] ptr);
        logic [3:0] vld_ext;
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [2:0] res;
        vld_ext = {1'b0, vld};
        c0 = (ptr > 2'd2) ? 2'd0 : ptr;
        c1 = rr_next(c0);
        c2 = rr_next(c1);
        if (vld_ext[c0]) begin
            res = {1'b1, c0};
        end else if (vld_ext[c1]) begin
            res = {1'b1, c1};
        end else if (vld_ext[c2]) begin
            res = {1'b1, c2};
        end else begin
            res = 3'b000;
        end
        return res;
    endfunction

    state_e               state_q;
    state_e               state_d;
    logic [1:0]           rr_ptr_q;
    logic [1:0]           rr_ptr_d;
    logic [2*WIDTH-1:0]   buf_q;
    logic [2*WIDTH-1:0]   buf_d;
    logic                 buf_two_q;
    logic                 buf_two_d;
`ifdef TX_ARB_HDR_EN
    // The source id is only needed to build the header byte.
    logic [1:0]           buf_id_q;
    logic [1:0]           buf_id_d;
    logic [WIDTH-1:0]     hdr_byte_s;
`endif
    logic [2:0]           pick_s;
    logic                 grant_s;
    logic [1:0]           grant_idx_s;
    logic [2:0]           ack_s;
    logic [WIDTH-1:0]     wr_data_s;

    assign pick_s      = rr_pick({REQ2_VLD, REQ1_VLD, REQ0_VLD}, rr_ptr_q);
    assign grant_s     = pick_s[2];
    assign grant_idx_s = pick_s[1:0];

    // Next-state, capture and acknowledge logic; grants happen only in IDLE.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        buf_d     = buf_q;
        buf_two_d = buf_two_q;
`ifdef TX_ARB_HDR_EN
        buf_id_d  = buf_id_q;
`endif
        ack_s     = 3'b000;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    // Ack is masked while reset is held so outputs read zero.
                    if (RST) begin
                        ack_s[grant_idx_s] = 1'b1;
                    end else begin
                        ack_s = 3'b000;
                    end
                    case (grant_idx_s)
                        2'd0: begin
                            buf_d     = REQ0_DATA;
                            buf_two_d = REQ0_TWO;
                        end
                        2'd1: begin
                            buf_d     = REQ1_DATA;
                            buf_two_d = REQ1_TWO;
                        end
                        2'd2: begin
                            buf_d     = REQ2_DATA;
                            buf_two_d = REQ2_TWO;
                        end
                        default: begin
                            buf_d     = {(2*WIDTH){1'b0}};
                            buf_two_d = 1'b0;
                        end
                    endcase
`ifdef TX_ARB_HDR_EN
                    buf_id_d = grant_idx_s;
                    state_d  = ST_SEND_HDR;
`else
                    state_d  = ST_SEND_LO;
`endif
                    rr_ptr_d = rr_next(grant_idx_s);
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef TX_ARB_HDR_EN
            ST_SEND_HDR: begin
                if (!FIFO_FULL) begin
                    state_d = ST_SEND_LO;
                end else begin
                    state_d = ST_SEND_HDR;
                end
            end
`endif
            ST_SEND_LO: begin
                if (!FIFO_FULL) begin
                    state_d = buf_two_q ? ST_SEND_HI : ST_IDLE;
                end else begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_HI: begin
                if (!FIFO_FULL) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND_HI;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and packet buffer flops; reset discards any packet in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 2'd0;
            buf_q     <= {(2*WIDTH){1'b0}};
            buf_two_q <= 1'b0;
`ifdef TX_ARB_HDR_EN
            buf_id_q  <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            buf_q     <= buf_d;
            buf_two_q <= buf_two_d;
`ifdef TX_ARB_HDR_EN
            buf_id_q  <= buf_id_d;
`endif
        end
    end

`ifdef TX_ARB_HDR_EN
    // Header byte: fixed 1010 tag, reserved zero, packet length flag, source id.
    always_comb begin
        hdr_byte_s      = {WIDTH{1'b0}};
        hdr_byte_s[7:0] = {4'b1010, 1'b0, buf_two_q, buf_id_q};
    end
`endif

    // Byte presented to the FIFO; held stable across a FIFO_FULL stall.
    always_comb begin
        wr_data_s = {WIDTH{1'b0}};
        case (state_q)
            ST_IDLE:     wr_data_s = {WIDTH{1'b0}};
`ifdef TX_ARB_HDR_EN
            ST_SEND_HDR: wr_data_s = hdr_byte_s;
`endif
            ST_SEND_LO:  wr_data_s = buf_q[WIDTH-1:0];
            ST_SEND_HI:  wr_data_s = buf_q[2*WIDTH-1:WIDTH];
            default:     wr_data_s = {WIDTH{1'b0}};
        endcase
    end

    assign REQ0_ACK     = ack_s[0];
    assign REQ1_ACK     = ack_s[1];
    assign REQ2_ACK     = ack_s[2];
    assign FIFO_WR_DATA = wr_data_s;
    assign FIFO_WR_INC  = (state_q != ST_IDLE) && !FIFO_FULL;
    assign BUSY         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Testbench for tx_resp_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_tx_resp_arbiter;
    localparam int WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [15:0] data [3];
    logic [2:0]  two;
    logic        full;
    logic        ack0;
    logic        ack1;
    logic        ack2;
    logic [7:0]  wr_data;
    logic        wr_inc;
    logic        busy;
    wire  [2:0]  ack_v = {ack2, ack1, ack0};

    always #5 clk = ~clk;

    tx_resp_arbiter #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst_n),
        .REQ0_VLD(vld[0]), .REQ1_VLD(vld[1]), .REQ2_VLD(vld[2]),
        .REQ0_DATA(data[0]), .REQ1_DATA(data[1]), .REQ2_DATA(data[2]),
        .REQ0_TWO(two[0]), .REQ1_TWO(two[1]), .REQ2_TWO(two[2]),
        .REQ0_ACK(ack0), .REQ1_ACK(ack1), .REQ2_ACK(ack2),
        .FIFO_FULL(full), .FIFO_WR_DATA(wr_data), .FIFO_WR_INC(wr_inc),
        .BUSY(busy)
    );

    int         checks = 0;
    int         failures = 0;
    int         rr = 0;          // model: highest-priority source
    logic [7:0] q[$];            // model: bytes still owed for current packet
    logic [7:0] wr_log[$];       // bytes the DUT actually wrote
    logic [7:0] exp_log[$];      // bytes a directed test expects
    int         ack_log[$];      // observed grant order
    logic [2:0] ack_seen = 3'b000;
    bit         hold_mode = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] hdr_byte(input int k, input bit t);
        logic [1:0] id;
        id = k[1:0];
        return {4'b1010, 1'b0, t, id};
    endfunction

    // Expected bytes of one packet from source k.
    task automatic add_exp(input int k, input logic [15:0] d, input bit t);
`ifdef TX_ARB_HDR_EN
        exp_log.push_back(hdr_byte(k, t));
`endif
        exp_log.push_back(d[7:0]);
        if (t) exp_log.push_back(d[15:8]);
    endtask

    task automatic compare_log(input string tag);
        check_value({tag, "_len"}, wr_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
            check_value({tag, "_byte"}, {24'h0, wr_log[i]}, {24'h0, exp_log[i]});
        wr_log.delete();
        exp_log.delete();
    endtask

    // One cycle: compare outputs against the model at negedge, advance the
    // model, then let sources react to ACK just after the next rising edge.
    task automatic tick();
        int k;
        int c;
        @(negedge clk);
        if (wr_inc) wr_log.push_back(wr_data);
        if (ack_v == 3'b001) ack_log.push_back(0);
        if (ack_v == 3'b010) ack_log.push_back(1);
        if (ack_v == 3'b100) ack_log.push_back(2);
        if (q.size() == 0) begin
            k = -1;
            for (int i = 0; i < 3; i++) begin
                c = (rr + i) % 3;
                if (k < 0 && vld[c]) k = c;
            end
            check_value("ack_idle", {29'h0, ack_v}, (k >= 0) ? (32'd1 << k) : 32'd0);
            check_value("busy_idle", {31'h0, busy}, 32'd0);
            check_value("inc_idle", {31'h0, wr_inc}, 32'd0);
            check_value("data_idle", {24'h0, wr_data}, 32'd0);
            if (k >= 0) begin
`ifdef TX_ARB_HDR_EN
                q.push_back(hdr_byte(k, two[k]));
`endif
                q.push_back(data[k][7:0]);
                if (two[k]) q.push_back(data[k][15:8]);
                rr = (k + 1) % 3;
            end
        end else begin
            check_value("ack_busy", {29'h0, ack_v}, 32'd0);
            check_value("busy_send", {31'h0, busy}, 32'd1);
            check_value("data_send", {24'h0, wr_data}, {24'h0, q[0]});
            check_value("inc_send", {31'h0, wr_inc}, {31'h0, !full});
            if (!full) void'(q.pop_front());
        end
        ack_seen = ack_v;
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++)
            if (ack_seen[s] && !hold_mode) vld[s] = 1'b0;
    endtask

    // Assert reset just after a rising edge, verify outputs clear at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_value("rst_ack", {29'h0, ack_v}, 32'd0);
        check_value("rst_busy", {31'h0, busy}, 32'd0);
        check_value("rst_inc", {31'h0, wr_inc}, 32'd0);
        check_value("rst_data", {24'h0, wr_data}, 32'd0);
        q.delete();
        rr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        vld = 3'b000;
        two = 3'b000;
        full = 1'b0;
        for (int s = 0; s < 3; s++) data[s] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        vld = 3'b111;   // requests during reset must not be acknowledged
        #1;
        check_value("por_ack", {29'h0, ack_v}, 32'd0);
        check_value("por_busy", {31'h0, busy}, 32'd0);
        check_value("por_data", {24'h0, wr_data}, 32'd0);
        vld = 3'b000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single one-byte packet from source 0.
        vld[0] = 1'b1; data[0] = 16'h005A; two[0] = 1'b0;
        add_exp(0, 16'h005A, 1'b0);
        repeat (4) tick();
        compare_log("one_byte");

        // Two-byte packet from source 1.
        vld[1] = 1'b1; data[1] = 16'h1234; two[1] = 1'b1;
        add_exp(1, 16'h1234, 1'b1);
        repeat (5) tick();
        compare_log("two_byte");

        // Round-robin order with all sources holding VLD.
        do_reset();
        ack_log.delete();
        hold_mode = 1'b1;
        two = 3'b000;
        data[0] = 16'h0011; data[1] = 16'h0022; data[2] = 16'h0033;
        vld = 3'b111;
`ifdef TX_ARB_HDR_EN
        repeat (18) tick();
`else
        repeat (12) tick();
`endif
        vld = 3'b000;
        hold_mode = 1'b0;
        repeat (4) tick();
        check_value("rr_count", ack_log.size(), 32'd6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            check_value("rr_order", ack_log[i], i % 3);
        wr_log.delete();

        // FIFO_FULL stall during the high byte.
        vld[1] = 1'b1; data[1] = 16'hABCD; two[1] = 1'b1;
        add_exp(1, 16'hABCD, 1'b1);
        tick();                  // grant
`ifdef TX_ARB_HDR_EN
        tick();                  // header
`endif
        tick();                  // low byte
        full = 1'b1;
        repeat (3) tick();       // held on high byte
        full = 1'b0;
        repeat (3) tick();
        compare_log("stall");

        // Reset in the middle of a two-byte packet.
        vld[0] = 1'b1; data[0] = 16'h7788; two[0] = 1'b1;
        tick();                  // grant
`ifdef TX_ARB_HDR_EN
        tick();
`endif
        wr_log.delete();
        do_reset();
        vld = 3'b111; two = 3'b000;
        ack_log.delete();
        tick();
        vld = 3'b000;
        repeat (4) tick();
        check_value("rst_rr_first", (ack_log.size() > 0) ? ack_log[0] : -1, 32'd0);
        for (int i = 0; i < wr_log.size(); i++)
            check_value("rst_no_hi", {31'h0, wr_log[i] == 8'h77}, 32'd0);
        wr_log.delete();

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 1500; n++) begin
            for (int s = 0; s < 3; s++) begin
                if (!vld[s] && !ack_seen[s] && $urandom_range(0, 3) == 0) begin
                    vld[s] = 1'b1;
                    data[s] = 16'($urandom);
                    two[s] = 1'($urandom);
                end
            end
            full = ($urandom_range(0, 3) == 0);
            tick();
        end
        vld = 3'b000;
        full = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
